// File: rtl/switch_debounce_pkg.sv
// sw_pkg: shared channel state encoding, default timing constants and counter sizing
package sw_pkg;

    typedef enum logic {IDLE, COUNT} ch_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch pins in, debounced levels and change events out
interface switch_debounce_if #(
    parameter int N_SW = 2
);

    logic [N_SW-1:0] sw_in;
    logic [N_SW-1:0] sw_stable;
    logic [N_SW-1:0] sw_rise;
    logic [N_SW-1:0] sw_fall;
    logic            sw_valid;

    modport master (output sw_in, input sw_stable, sw_rise, sw_fall, sw_valid);
    modport slave  (input sw_in, output sw_stable, sw_rise, sw_fall, sw_valid);

endinterface

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit: one channel - synchronizer, agreement counter, stable level and edge pulses
module switch_debounce_bit
    import sw_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic chg
);

    localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    ch_state_t              state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   differ, expire;
    logic                   stable_n, rise_n, fall_n;

    assign s      = sync[SYNC_STAGES-1];
    assign differ = s != stable;
    assign expire = state == COUNT && differ && cnt == LAST;
    assign chg    = rise_n | fall_n;

    // bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], din};
    end

    // channel state, counter, accepted level and registered edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            stable <= stable_n;
            rise   <= rise_n;
            fall   <= fall_n;
        end
    end

    // any agreeing sample aborts the count; expiry returns to IDLE with the counter cleared
    always_comb begin
        state_n = !differ ? IDLE : (state == IDLE ? COUNT : (expire ? IDLE : COUNT));
        cnt_n   = !differ ? '0 : (state == IDLE ? CW'(1) : (expire ? '0 : cnt + 1'b1));
    end

    // on expiry adopt the synchronized level and flag its direction
    always_comb begin
        stable_n = expire ? s : stable;
        rise_n   = expire & s;
        fall_n   = expire & ~s;
    end

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: N_SW independent debounce channels plus a combined change strobe
module switch_debounce
    import sw_pkg::*;
#(
    parameter int N_SW            = 2,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input logic               clk,
    input logic               rst,
    switch_debounce_if.slave  bus
);

    logic [N_SW-1:0] chg;

    genvar i;
    generate
        for (i = 0; i < N_SW; i++) begin : g_ch
            switch_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk    (clk),
                .rst    (rst),
                .din    (bus.sw_in[i]),
                .stable (bus.sw_stable[i]),
                .rise   (bus.sw_rise[i]),
                .fall   (bus.sw_fall[i]),
                .chg    (chg[i])
            );
        end
    endgenerate

    // registered alongside the per-bit pulses so it lands on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.sw_valid <= 1'b0;
        else     bus.sw_valid <= |chg;
    end

endmodule
